// File: rtl/col_feeder_pkg.sv
// Shared constants and types for the column-pair operand feeder.
// Build option FEEDER_TAG_EN adds a 4-bit sequence tag to every result.
package col_feeder_pkg;

  localparam int WORD_W        = 32;
  localparam int COL_W         = 256;
  localparam int RES_W         = 10;
  localparam int DUT_LAT       = 1;
  localparam int FIFO_DEPTH    = 4;
  localparam int BEATS_PER_COL = COL_W / WORD_W;
  localparam int TAG_W         = 4;

`ifdef FEEDER_TAG_EN
  localparam int TAG_EXT = TAG_W;
`else
  localparam int TAG_EXT = 0;
`endif

  typedef enum logic [1:0] {
    LOAD0 = 2'd0,
    LOAD1 = 2'd1,
    ISSUE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/col_pair_feeder_if.sv
// Word-in / result-out stream bundle of the column-pair feeder.
// MW is RES_W, or RES_W+TAG_W when FEEDER_TAG_EN is defined.
interface col_pair_feeder_if #(
  parameter int WORD_W = col_feeder_pkg::WORD_W,
  parameter int MW     = col_feeder_pkg::RES_W + col_feeder_pkg::TAG_EXT
);
  // Both streams: a beat transfers on a rising edge where valid && ready; the
  // source holds data stable while valid is high and ready is low, and valid
  // never depends combinationally on ready.
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [MW-1:0]     m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/col_result_fifo.sv
// Synchronous show-ahead FIFO holding compute-unit results.
// DEPTH must be a power of two so the pointers wrap naturally.
module col_result_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // The feeder's credit scheme must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/col_pair_feeder.sv
// Assembles col0/col1 from a word stream, issues them to the column compute unit,
// tracks its latency and buffers results. FEEDER_TAG_EN prepends a sequence tag.
module col_pair_feeder #(
  parameter int WORD_W     = col_feeder_pkg::WORD_W,
  parameter int COL_W      = col_feeder_pkg::COL_W,
  parameter int RES_W      = col_feeder_pkg::RES_W,
  parameter int DUT_LAT    = col_feeder_pkg::DUT_LAT,
  parameter int FIFO_DEPTH = col_feeder_pkg::FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  col_pair_feeder_if.slave bus,
  output logic [COL_W-1:0] in_col0,
  output logic [COL_W-1:0] in_col1,
  input  logic [RES_W-1:0] comp_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  import col_feeder_pkg::*;

  localparam int BEATS = COL_W / WORD_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int MW    = RES_W + TAG_EXT;

  localparam logic [1:0] ST_LOAD0 = LOAD0;
  localparam logic [1:0] ST_LOAD1 = LOAD1;
  localparam logic [1:0] ST_ISSUE = ISSUE;

  logic [1:0]         state;
  logic [BW-1:0]      beat;
  logic               rdy_q;
  logic [COL_W-1:0]   sh0;
  logic [COL_W-1:0]   sh1;
  logic [DUT_LAT-1:0] vline;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               accept;
  logic               issue;
  logic               capture;
  logic               pop;
  logic [MW-1:0]      push_data;
  logic [MW-1:0]      head;

  // rdy_q keeps s_ready low for the first cycle out of reset.
  assign bus.s_ready = rdy_q && (state != ST_ISSUE);
  assign accept      = bus.s_valid && bus.s_ready;
  assign capture     = vline[DUT_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < DUT_LAT; i++) inflight = inflight + CW'(vline[i]);
  end

  // Credit = FIFO_DEPTH - (buffered + in flight); every issued op has a reserved slot.
  assign issue = (state == ST_ISSUE) && ((fifo_count + inflight) < CW'(FIFO_DEPTH)) && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LOAD0;
      beat    <= '0;
      rdy_q   <= 1'b0;
      sh0     <= '0;
      sh1     <= '0;
      in_col0 <= '0;
      in_col1 <= '0;
      vline   <= '0;
    end else begin
      rdy_q <= 1'b1;
      vline <= (vline << 1) | DUT_LAT'(issue);
      if (accept) begin
        for (int k = 0; k < BEATS; k++) begin
          if (beat == BW'(k)) begin
            if (state == ST_LOAD0) sh0[k*WORD_W +: WORD_W] <= bus.s_data;
            else                   sh1[k*WORD_W +: WORD_W] <= bus.s_data;
          end
        end
        if (beat == BW'(BEATS - 1)) begin
          beat  <= '0;
          state <= (state == ST_LOAD0) ? ST_LOAD1 : ST_ISSUE;
        end else begin
          beat <= beat + BW'(1);
        end
      end
      if (issue) begin
        in_col0 <= sh0;
        in_col1 <= sh1;
        state   <= ST_LOAD0;
      end
    end
  end

`ifdef FEEDER_TAG_EN
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] tag_line [DUT_LAT];

  // The tag shifts alongside the valid line so it reaches the FIFO with its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt <= '0;
      for (int i = 0; i < DUT_LAT; i++) tag_line[i] <= '0;
    end else begin
      tag_line[0] <= tag_cnt;
      for (int i = 1; i < DUT_LAT; i++) tag_line[i] <= tag_line[i-1];
      if (issue) tag_cnt <= tag_cnt + TAG_W'(1);
    end
  end

  assign push_data = {tag_line[DUT_LAT-1], comp_out};
`else
  assign push_data = comp_out;
`endif

  col_result_fifo #(
    .WIDTH (MW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign pop         = !fifo_empty && bus.m_ready;
  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = fifo_empty ? '0 : head;
  assign busy        = (state != ST_LOAD0) || (beat != '0) || (inflight != '0) || (fifo_count != '0);
  assign dbg_state   = state;

endmodule

// File: tb/tb_col_pair_feeder.sv
// Bench for col_pair_feeder: randomized ops against an operand/result model and
// a stand-in compute unit (result = col0[9:0] ^ col1[9:0], latency 1).
module tb_col_pair_feeder;
  import col_feeder_pkg::*;

  localparam int MW = RES_W + TAG_EXT;
  localparam int NW = 2 * BEATS_PER_COL;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  col_pair_feeder_if #(.WORD_W(WORD_W), .MW(MW)) bus ();

  logic [COL_W-1:0] in_col0;
  logic [COL_W-1:0] in_col1;
  logic [RES_W-1:0] comp_out;
  logic             busy;
  logic [1:0]       dbg_state;

  assign comp_out = in_col0[RES_W-1:0] ^ in_col1[RES_W-1:0];

  col_pair_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .in_col0   (in_col0),
    .in_col1   (in_col1),
    .comp_out  (comp_out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [MW-1:0]    exp_q[$];
  logic [COL_W-1:0] col0_q[$];
  logic [COL_W-1:0] col1_q[$];
  int               n_cmp;
  int               n_fail;
  int               op_seq;
  bit               rand_ready_en;

  task automatic check(input string name, input logic [COL_W-1:0] act, input logic [COL_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready_en) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    int guard;
    guard       = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    while (!bus.s_ready && guard < 500) begin
      tick();
      guard++;
    end
    if (!bus.s_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL s_ready_timeout: got 0 expected 1 within 500 cycles");
    end
    tick();
    bus.s_valid = 1'b0;
  endtask

  // Model: col0 = words 0..7 LS word first, col1 = words 8..15; result = low RES_W bits XORed.
  task automatic send_op(input logic [WORD_W-1:0] w [NW], input int gap_pct, input bit expect_it);
    logic [COL_W-1:0] c0;
    logic [COL_W-1:0] c1;
    logic [RES_W-1:0] r;
    for (int k = 0; k < BEATS_PER_COL; k++) begin
      c0[k*WORD_W +: WORD_W] = w[k];
      c1[k*WORD_W +: WORD_W] = w[BEATS_PER_COL + k];
    end
    r = c0[RES_W-1:0] ^ c1[RES_W-1:0];
    if (expect_it) begin
`ifdef FEEDER_TAG_EN
      exp_q.push_back({TAG_W'(op_seq), r});
`else
      exp_q.push_back(r);
`endif
      col0_q.push_back(c0);
      col1_q.push_back(c1);
      op_seq++;
    end
    for (int k = 0; k < NW; k++) begin
      send_word(w[k]);
      if (int'($urandom_range(0, 99)) < gap_pct) tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    col0_q.delete();
    col1_q.delete();
    op_seq = 0;
    check("rst_s_ready", bus.s_ready, 1'b0);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_data", bus.m_data, '0);
    check("rst_in_col0", in_col0, '0);
    check("rst_in_col1", in_col1, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, LOAD0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("s_ready_after_reset", bus.s_ready, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 3000) begin
      tick();
      guard++;
    end
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [1:0]    prev;
    logic [MW-1:0] e;
    prev = LOAD0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = LOAD0;
      end else begin
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL m_data_unexpected: got 0x%0h expected no result", bus.m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", bus.m_data, e);
          end
        end
        if (prev == ISSUE && dbg_state != ISSUE) begin
          if (col0_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_unexpected: got issue expected none");
          end else begin
            check("in_col0", in_col0, col0_q.pop_front());
            check("in_col1", in_col1, col1_q.pop_front());
          end
        end
        prev = dbg_state;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WORD_W-1:0] w [NW];
    n_cmp         = 0;
    n_fail        = 0;
    op_seq        = 0;
    rand_ready_en = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
    fork
      monitor();
    join_none
    do_reset();

    // Fixed words, continuous stream.
    for (int k = 0; k < NW; k++)
      w[k] = (k < BEATS_PER_COL) ? WORD_W'(k + 1) : WORD_W'(32'h11 + k - BEATS_PER_COL);
    bus.m_ready = 1'b1;
    send_op(w, 0, 1'b1);
    wait_idle("t1");

    // Same words with s_valid low every other cycle.
    send_op(w, 100, 1'b1);
    wait_idle("t3");

    // Consumer stalled: 4 results buffer, the fifth op waits in ISSUE.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NW; k++) w[k] = $urandom();
      send_op(w, 0, 1'b1);
    end
    repeat (4) tick();
    check("t2_stall_s_ready", bus.s_ready, 1'b0);
    check("t2_stall_state", dbg_state, ISSUE);
    check("t2_m_valid", bus.m_valid, 1'b1);
    bus.m_ready = 1'b1;
    wait_idle("t2");

    // Capture and pop on the same edge with 3 entries buffered.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NW; k++) w[k] = $urandom();
      send_op(w, 0, 1'b1);
    end
    repeat (3) tick();
    for (int k = 0; k < NW; k++) w[k] = $urandom();
    send_op(w, 0, 1'b1);
    tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    for (int k = 0; k < NW; k++) w[k] = $urandom();
    send_op(w, 0, 1'b1);
    repeat (3) tick();
    check("t4_op5_issued", dbg_state, LOAD0);
    bus.m_ready = 1'b1;
    wait_idle("t4");

    // Reset with a buffered result and a fully loaded op about to issue.
    bus.m_ready = 1'b0;
    for (int k = 0; k < NW; k++) w[k] = $urandom();
    send_op(w, 0, 1'b1);
    repeat (2) tick();
    for (int k = 0; k < NW; k++) w[k] = $urandom();
    send_op(w, 0, 1'b0);
    do_reset();
    bus.m_ready = 1'b1;
    for (int k = 0; k < NW; k++) w[k] = $urandom();
    send_op(w, 0, 1'b1);
    wait_idle("t5");

    // Random traffic: 17 ops from reset so tags run 0..15 then 0.
    do_reset();
    rand_ready_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < NW; k++) w[k] = $urandom();
      send_op(w, 30, 1'b1);
    end
    wait_idle("t6");
    rand_ready_en = 1'b0;
    bus.m_ready   = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
